// File: rtl/nav_pkg.sv
// Shared types for the wall-following navigation sequencer.
package nav_pkg;

   // Navigation states; the numeric values are exposed on state_out for debug.
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      FORWARD     = 3'd1,
      TURN_RIGHT  = 3'd2,
      TURN_LEFT   = 3'd3,
      TURN_AROUND = 3'd4,
      SETTLE      = 3'd5
   } states_t;

   // Open-vector layout is {right, forward, left}.
   localparam int OPEN_W     = 3;
   localparam int OPEN_R_BIT = 2;
   localparam int OPEN_F_BIT = 1;
   localparam int OPEN_L_BIT = 0;

   // Largest of three cycle counts, used to size the shared state timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ir_debounce.sv
// Thresholds the three IR readings into an open vector and reports when the
// same vector has been seen on DEBOUNCE_SAMPLES consecutive strobes.
module ir_debounce
   import nav_pkg::*;
#(
   parameter int IR_W             = 16,
   parameter int OPEN_THRESH      = 1000,
   parameter int DEBOUNCE_SAMPLES = 4
) (
   input  logic              clk_in,
   input  logic              reset_n_in,
   input  logic              clear_in,
   input  logic              strobe_in,
   input  logic [IR_W-1:0]   right_ir,
   input  logic [IR_W-1:0]   forward_ir,
   input  logic [IR_W-1:0]   left_ir,
   output logic [OPEN_W-1:0] vec_out,
   output logic              stable_out
);

   localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
   localparam logic [IR_W-1:0]  THRESH  = IR_W'(OPEN_THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES);

   logic [OPEN_W-1:0] open_vec;
   logic [OPEN_W-1:0] vec_d, vec_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   // Compare each reading against the threshold and update the run counter on strobes.
   always_comb begin
      open_vec             = '0;
      open_vec[OPEN_R_BIT] = (right_ir > THRESH);
      open_vec[OPEN_F_BIT] = (forward_ir > THRESH);
      open_vec[OPEN_L_BIT] = (left_ir > THRESH);
      vec_d = vec_q;
      cnt_d = cnt_q;
      if (clear_in) begin
         cnt_d = '0;
      end else if (strobe_in) begin
         if (open_vec == vec_q) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            vec_d = open_vec;
            cnt_d = CNT_W'(1);
         end
      end
   end

   // Hold the last sampled vector and its run length.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         vec_q <= '0;
         cnt_q <= '0;
      end else begin
         vec_q <= vec_d;
         cnt_q <= cnt_d;
      end
   end

   assign vec_out    = vec_q;
   assign stable_out = (cnt_q == CNT_MAX);

endmodule

// File: rtl/wall_follow_nav.sv
// Right-hand-rule navigation sequencer: debounced IR decisions, timed turns,
// a settle phase after each turn, and Moore-decoded wheel commands.
module wall_follow_nav
   import nav_pkg::*;
#(
   parameter int IR_W             = 16,
   parameter int RPM_W            = 21,
   parameter int OPEN_THRESH      = 1000,
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int TURN_CYCLES      = 50_000_000,
   parameter int AROUND_CYCLES    = 100_000_000,
   parameter int SETTLE_CYCLES    = 25_000_000,
   parameter int BASE_RPM         = 100,
   parameter int TURN_RPM         = 50
) (
   input  logic             clk_in,
   input  logic             reset_n_in,
   input  logic             enable_in,
   input  logic             sample_valid_in,
   input  logic [IR_W-1:0]  right_ir,
   input  logic [IR_W-1:0]  forward_ir,
   input  logic [IR_W-1:0]  left_ir,
   output logic [RPM_W-1:0] rpm_left_setpoint,
   output logic [RPM_W-1:0] rpm_right_setpoint,
   output logic             left_motor_en,
   output logic             right_motor_en,
   output logic             left_motor_direction,
   output logic             right_motor_direction,
   output logic [2:0]       state_out,
   output logic             busy_out
);

   localparam int MAX_CYC = max3(TURN_CYCLES, AROUND_CYCLES, SETTLE_CYCLES);
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TMR_W-1:0] TURN_LOAD   = TMR_W'(TURN_CYCLES - 1);
   localparam logic [TMR_W-1:0] AROUND_LOAD = TMR_W'(AROUND_CYCLES - 1);
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [RPM_W-1:0] BASE_SP     = RPM_W'(BASE_RPM);
   localparam logic [RPM_W-1:0] TURN_SP     = RPM_W'(TURN_RPM);

   states_t           state_d, state_q;
   logic [TMR_W-1:0]  timer_d, timer_q;
   logic [OPEN_W-1:0] open_vec;
   logic              stable;
   logic              deb_clear;

   ir_debounce #(
      .IR_W             (IR_W),
      .OPEN_THRESH      (OPEN_THRESH),
      .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
   ) u_debounce (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .clear_in   (deb_clear),
      .strobe_in  (sample_valid_in),
      .right_ir   (right_ir),
      .forward_ir (forward_ir),
      .left_ir    (left_ir),
      .vec_out    (open_vec),
      .stable_out (stable)
   );

   // Next-state and timer logic; dropping enable overrides every other transition.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (!enable_in) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FORWARD;
               timer_d = '0;
            end
            FORWARD: begin
               if (stable) begin
                  if (open_vec[OPEN_R_BIT]) begin
                     state_d = TURN_RIGHT;
                     timer_d = TURN_LOAD;
                  end else if (open_vec[OPEN_F_BIT]) begin
                     state_d = FORWARD;
                  end else if (open_vec[OPEN_L_BIT]) begin
                     state_d = TURN_LEFT;
                     timer_d = TURN_LOAD;
                  end else begin
                     state_d = TURN_AROUND;
                     timer_d = AROUND_LOAD;
                  end
               end
            end
            TURN_RIGHT, TURN_LEFT, TURN_AROUND: begin
               if (timer_q == '0) begin
                  state_d = SETTLE;
                  timer_d = SETTLE_LOAD;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            SETTLE: begin
               if (timer_q == '0) begin
                  state_d = FORWARD;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // Restart debouncing whenever navigation (re)starts or stops.
   always_comb begin
      deb_clear = !enable_in ||
                  ((state_d != state_q) && ((state_d == FORWARD) || (state_d == IDLE)));
   end

   // State register and residency timer.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Moore decode of wheel commands from the state register.
   always_comb begin
      rpm_left_setpoint     = '0;
      rpm_right_setpoint    = '0;
      left_motor_en         = 1'b0;
      right_motor_en        = 1'b0;
      left_motor_direction  = 1'b1;
      right_motor_direction = 1'b1;
      busy_out              = 1'b0;
      case (state_q)
         FORWARD: begin
            rpm_left_setpoint  = BASE_SP;
            rpm_right_setpoint = BASE_SP;
            left_motor_en      = 1'b1;
            right_motor_en     = 1'b1;
         end
         TURN_RIGHT: begin
            rpm_left_setpoint  = BASE_SP;
            rpm_right_setpoint = TURN_SP;
            left_motor_en      = 1'b1;
            right_motor_en     = 1'b1;
            busy_out           = 1'b1;
         end
         TURN_LEFT: begin
            rpm_left_setpoint  = TURN_SP;
            rpm_right_setpoint = BASE_SP;
            left_motor_en      = 1'b1;
            right_motor_en     = 1'b1;
            busy_out           = 1'b1;
         end
         TURN_AROUND: begin
            rpm_left_setpoint     = BASE_SP;
            rpm_right_setpoint    = BASE_SP;
            left_motor_en         = 1'b1;
            right_motor_en        = 1'b1;
            right_motor_direction = 1'b0;
            busy_out              = 1'b1;
         end
         SETTLE: begin
            rpm_left_setpoint  = BASE_SP;
            rpm_right_setpoint = BASE_SP;
            left_motor_en      = 1'b1;
            right_motor_en     = 1'b1;
            busy_out           = 1'b1;
         end
         default: begin
            rpm_left_setpoint = '0;
         end
      endcase
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_wall_follow_nav.sv
// Self-checking bench for wall_follow_nav: directed scenarios followed by
// randomized traffic, all compared against a behavioural navigation model.
module tb_wall_follow_nav;

   localparam int IR_W     = 16;
   localparam int RPM_W    = 21;
   localparam int THRESH   = 1000;
   localparam int DEB      = 3;
   localparam int TURN_N   = 8;
   localparam int AROUND_N = 16;
   localparam int SETTLE_N = 4;
   localparam int BASE     = 100;
   localparam int TURNSP   = 50;

   // Modes of the reference model, numbered as the debug state encoding.
   localparam int M_IDLE   = 0;
   localparam int M_FWD    = 1;
   localparam int M_RIGHT  = 2;
   localparam int M_LEFT   = 3;
   localparam int M_AROUND = 4;
   localparam int M_SETTLE = 5;

   logic             clk_in = 1'b0;
   logic             reset_n_in = 1'b1;
   logic             enable_in = 1'b0;
   logic             sample_valid_in = 1'b0;
   logic [IR_W-1:0]  right_ir = '0;
   logic [IR_W-1:0]  forward_ir = '0;
   logic [IR_W-1:0]  left_ir = '0;
   logic [RPM_W-1:0] rpm_left_setpoint;
   logic [RPM_W-1:0] rpm_right_setpoint;
   logic             left_motor_en;
   logic             right_motor_en;
   logic             left_motor_direction;
   logic             right_motor_direction;
   logic [2:0]       state_out;
   logic             busy_out;

   int nChecks = 0;
   int nFail = 0;

   // Reference model: current mode, cycles left in a timed mode, and the
   // open vectors seen since the debounce was last restarted.
   int       mMode = M_IDLE;
   int       mRem = 0;
   bit [2:0] hist[$];

   wall_follow_nav #(
      .IR_W             (IR_W),
      .RPM_W            (RPM_W),
      .OPEN_THRESH      (THRESH),
      .DEBOUNCE_SAMPLES (DEB),
      .TURN_CYCLES      (TURN_N),
      .AROUND_CYCLES    (AROUND_N),
      .SETTLE_CYCLES    (SETTLE_N),
      .BASE_RPM         (BASE),
      .TURN_RPM         (TURNSP)
   ) dut (
      .clk_in                (clk_in),
      .reset_n_in            (reset_n_in),
      .enable_in             (enable_in),
      .sample_valid_in       (sample_valid_in),
      .right_ir              (right_ir),
      .forward_ir            (forward_ir),
      .left_ir               (left_ir),
      .rpm_left_setpoint     (rpm_left_setpoint),
      .rpm_right_setpoint    (rpm_right_setpoint),
      .left_motor_en         (left_motor_en),
      .right_motor_en        (right_motor_en),
      .left_motor_direction  (left_motor_direction),
      .right_motor_direction (right_motor_direction),
      .state_out             (state_out),
      .busy_out              (busy_out)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected wheel commands for a mode, packed {busy, en_l, en_r, dir_l, dir_r, sp_l, sp_r}.
   function automatic logic [63:0] expOuts(input int mode);
      logic [63:0] v;
      int spL, spR;
      bit busy, en, dirR;
      spL = BASE; spR = BASE; busy = 1'b0; en = 1'b1; dirR = 1'b1;
      case (mode)
         M_IDLE:   begin spL = 0; spR = 0; en = 1'b0; end
         M_RIGHT:  begin spR = TURNSP; busy = 1'b1; end
         M_LEFT:   begin spL = TURNSP; busy = 1'b1; end
         M_AROUND: begin dirR = 1'b0; busy = 1'b1; end
         M_SETTLE: busy = 1'b1;
         default:  busy = 1'b0;
      endcase
      v = {17'd0, busy, en, en, 1'b1, dirR, RPM_W'(spL), RPM_W'(spR)};
      return v;
   endfunction

   function automatic logic [63:0] obsOuts();
      logic [63:0] v;
      v = {17'd0, busy_out, left_motor_en, right_motor_en, left_motor_direction,
           right_motor_direction, rpm_left_setpoint, rpm_right_setpoint};
      return v;
   endfunction

   function automatic bit modelStable();
      if (hist.size() != DEB) return 1'b0;
      foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic modelReset();
      mMode = M_IDLE;
      mRem = 0;
      hist.delete();
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelStep(input bit en, input bit stb, input int r, input int f, input int l);
      bit       st;
      bit [2:0] v;
      bit [2:0] hv;
      int       nxt, nrem;
      bit       clr;
      st = modelStable();
      hv = (hist.size() > 0) ? hist[hist.size()-1] : 3'b000;
      v  = {r > THRESH, f > THRESH, l > THRESH};
      nxt = mMode; nrem = mRem;
      if (!en) begin
         nxt = M_IDLE; nrem = 0;
      end else begin
         case (mMode)
            M_IDLE: nxt = M_FWD;
            M_FWD: if (st) begin
               if (hv[2])      begin nxt = M_RIGHT;  nrem = TURN_N;   end
               else if (hv[1]) nxt = M_FWD;
               else if (hv[0]) begin nxt = M_LEFT;   nrem = TURN_N;   end
               else            begin nxt = M_AROUND; nrem = AROUND_N; end
            end
            M_RIGHT, M_LEFT, M_AROUND:
               if (mRem <= 1) begin nxt = M_SETTLE; nrem = SETTLE_N; end
               else nrem = mRem - 1;
            default:
               if (mRem <= 1) begin nxt = M_FWD; nrem = 0; end
               else nrem = mRem - 1;
         endcase
      end
      clr = !en || ((nxt != mMode) && ((nxt == M_FWD) || (nxt == M_IDLE)));
      if (clr) hist.delete();
      else if (stb) begin
         hist.push_back(v);
         if (hist.size() > DEB) void'(hist.pop_front());
      end
      mMode = nxt;
      mRem = nrem;
   endtask

   // Drive one cycle of inputs, clock it, and compare DUT against the model.
   task automatic applyStimulus(input bit en, input bit stb, input int r, input int f, input int l);
      enable_in       = en;
      sample_valid_in = stb;
      right_ir        = IR_W'(r);
      forward_ir      = IR_W'(f);
      left_ir         = IR_W'(l);
      @(posedge clk_in);
      modelStep(en, stb, r, f, l);
      #1;
      checkOutput("state", 64'(state_out), 64'(mMode));
      checkOutput("outs", obsOuts(), expOuts(mMode));
   endtask

   // Pulse reset between clock edges and confirm outputs clear without a clock.
   task automatic pulseReset(input string tag);
      #2;
      reset_n_in = 1'b0;
      modelReset();
      #1;
      checkOutput({tag, "_state"}, 64'(state_out), 64'(M_IDLE));
      checkOutput({tag, "_outs"}, obsOuts(), expOuts(M_IDLE));
      #3;
      reset_n_in = 1'b1;
   endtask

   function automatic int pickIr();
      case ($urandom_range(0, 7))
         0: return 0;
         1: return 999;
         2: return 1000;
         3: return 1001;
         4: return 1500;
         5: return 65535;
         default: return int'($urandom_range(0, 65535));
      endcase
   endfunction

   initial begin
      int busyCount;
      int r, f, l;
      bit en, stb;

      // Reset state.
      #2 reset_n_in = 1'b0;
      modelReset();
      #10;
      checkOutput("reset_state", 64'(state_out), 64'(M_IDLE));
      checkOutput("reset_outs", obsOuts(), expOuts(M_IDLE));
      reset_n_in = 1'b1;

      // Enable: IDLE to FORWARD.
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("enable_fwd", 64'(state_out), 64'(M_FWD));

      // Right open for three strobes: timed right turn then settle.
      repeat (3) applyStimulus(1, 1, 1500, 0, 0);
      busyCount = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         if (busy_out) busyCount++;
      end
      checkOutput("right_busy_cycles", 64'(busyCount), 64'(TURN_N + SETTLE_N));
      checkOutput("right_back_fwd", 64'(state_out), 64'(M_FWD));

      // Broken run: two right-open then closed samples, no turn until three closed.
      repeat (2) applyStimulus(1, 1, 1500, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("no_turn_broken_run", 64'(state_out), 64'(M_FWD));
      repeat (2) applyStimulus(1, 1, 0, 0, 0);
      busyCount = 0;
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1, 0, 0, 0, 0);
         if (state_out == 3'(M_AROUND) && !right_motor_direction) busyCount++;
      end
      checkOutput("around_cycles", 64'(busyCount), 64'(AROUND_N));

      // Threshold is strict: right=1000 is closed, forward open keeps cruising.
      repeat (3) applyStimulus(1, 1, 1000, 2000, 0);
      repeat (3) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("thresh_stay_fwd", 64'(state_out), 64'(M_FWD));
      repeat (3) applyStimulus(1, 1, 0, 0, 1001);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("left_turn", 64'(state_out), 64'(M_LEFT));

      // Drop enable during the third TURN_LEFT cycle, then re-debounce.
      repeat (2) applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("disable_idle", 64'(state_out), 64'(M_IDLE));
      applyStimulus(1, 0, 0, 0, 0);
      repeat (2) applyStimulus(1, 1, 0, 0, 1001);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("reenable_no_turn", 64'(state_out), 64'(M_FWD));
      applyStimulus(1, 1, 0, 0, 1001);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("reenable_left", 64'(state_out), 64'(M_LEFT));

      // Let the turn finish, then reset asynchronously mid-TURN_AROUND.
      repeat (16) applyStimulus(1, 0, 0, 0, 0);
      repeat (3) applyStimulus(1, 1, 0, 0, 0);
      repeat (5) applyStimulus(1, 0, 0, 0, 0);
      checkOutput("pre_reset_around", 64'(state_out), 64'(M_AROUND));
      pulseReset("async_reset");
      applyStimulus(1, 0, 0, 0, 0);

      // Randomized traffic with sticky readings so debounced runs occur.
      r = 0; f = 0; l = 0;
      for (int i = 0; i < 4000; i++) begin
         en  = ($urandom_range(0, 149) != 0);
         stb = ($urandom_range(0, 2) == 0);
         if (stb && $urandom_range(0, 5) == 0) begin
            r = pickIr(); f = pickIr(); l = pickIr();
         end
         applyStimulus(en, stb, r, f, l);
         if ($urandom_range(0, 699) == 0) pulseReset("rand_reset");
      end

      $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
      $finish;
   end

endmodule

// File: doc/wall_follow_nav.md
# wall_follow_nav

Parametrised navigation sequencer for the wall-following robot. It sits between the IR sensor front end and the two per-wheel PID speed loops. It debounces the three IR distance readings, picks a manoeuvre with right-hand-rule priority, and runs each turn for a timed number of cycles. During each state it drives the per-wheel RPM setpoints, enables and directions. Unlike the previous single-step FSM, it adds an enable/idle state, a 16-bit forward sensor, sample debouncing, timed turns and a post-turn settle phase.

## Interface
Parameters:
- IR_W, 16, width of each IR reading
- RPM_W, 21, width of each RPM setpoint
- OPEN_THRESH, 1000, a reading strictly greater than this means that side is open
- DEBOUNCE_SAMPLES, 4, consecutive identical open-vectors needed before acting (≥1)
- TURN_CYCLES, 50_000_000, cycles spent in TURN_LEFT or TURN_RIGHT (≥1)
- AROUND_CYCLES, 100_000_000, cycles spent in TURN_AROUND (≥1)
- SETTLE_CYCLES, 25_000_000, cycles spent in SETTLE (≥1)
- BASE_RPM, 100, cruise setpoint
- TURN_RPM, 50, setpoint for the inner wheel during a turn

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous, active-low reset
- enable_in  input  1  1 = navigate; 0 = stop
- sample_valid_in  input  1  one-cycle strobe: the three IR inputs hold a new reading
- right_ir  input  IR_W  right distance reading
- forward_ir  input  IR_W  forward distance reading
- left_ir  input  IR_W  left distance reading
- rpm_left_setpoint  output  RPM_W  desired left wheel RPM
- rpm_right_setpoint  output  RPM_W  desired right wheel RPM
- left_motor_en  output  1  left motor enable
- right_motor_en  output  1  right motor enable
- left_motor_direction  output  1  left direction, 1 = forward
- right_motor_direction  output  1  right direction, 1 = forward
- state_out  output  3  current state encoding, for debug
- busy_out  output  1  1 while in TURN_* or SETTLE

## Operation
- Open vector: {r,f,l}, where each bit = (ir > OPEN_THRESH), unsigned and strict. It is sampled only on sample_valid_in.
- Debounce on each strobe:
  - If the vector equals the previously sampled vector, increment the count, saturating at DEBOUNCE_SAMPLES.
  - Otherwise, store the new vector and set the count to 1.
  - `stable` = (count == DEBOUNCE_SAMPLES).
  - The count is cleared to 0 on entry to FORWARD and on entry to IDLE.
- States: IDLE, FORWARD, TURN_RIGHT, TURN_LEFT, TURN_AROUND, SETTLE.
- IDLE:
  - Outputs: enables 0, setpoints 0, directions 1.
  - enable_in=1 → FORWARD.
- FORWARD:
  - Outputs: both wheels BASE_RPM, forward.
  - Decision is taken only when `stable` is set. Priority:
    - r → TURN_RIGHT
    - else f → stay in FORWARD
    - else l → TURN_LEFT
    - else → TURN_AROUND
- TURN_RIGHT: left wheel BASE_RPM, right wheel TURN_RPM, both forward.
- TURN_LEFT: left wheel TURN_RPM, right wheel BASE_RPM, both forward.
- TURN_AROUND: both wheels BASE_RPM, left forward, right reverse (pivot).
- Turn exit: each TURN_* state loads its timer on entry and goes to SETTLE when the timer expires.
- SETTLE:
  - Outputs: same as FORWARD.
  - Ignores the IR inputs.
  - Goes to FORWARD after SETTLE_CYCLES.
- enable_in=0 in any state → IDLE on the next edge. This overrides every other transition; the timer and debounce count are cleared.
- All outputs are a Moore decode of the state register only.

## Timing
- Reset (reset_n_in low, asynchronous) gives:
  - state IDLE, all setpoints 0, enables 0, directions 1
  - state_out = IDLE encoding, busy_out 0
  - timer 0, debounce count 0, stored vector 0
- Decision latency: the state changes on the edge after the strobe that makes `stable` true.
- Timed residency: each timed state lasts exactly its parameter count of cycles. The timer is a down-counter loaded with N−1 on entry; the state exits on the edge where the timer is 0.
- Timer width: $clog2 of the largest timing parameter, minimum 1.
- Strobe arriving on the same edge as FORWARD entry: it is ignored, because the debounce clear wins.
- Forward-open while stable: the FSM stays in FORWARD and re-evaluates on every strobe; it issues no new turn.
- reset_n_in asserted mid-turn: outputs go to IDLE values immediately, without waiting for a clock edge.

## Structure
- Package nav_pkg holds:
  - the states_t enum: IDLE=0, FORWARD=1, TURN_RIGHT=2, TURN_LEFT=3, TURN_AROUND=4, SETTLE=5
  - the open-vector bit indices
- Sub-module ir_debounce:
  - contains the threshold compare, stored vector and saturating counter
  - inputs: clear, strobe and the three readings
  - outputs: vector and `stable`
- The top level holds the FSM, the timer and the output decode.

## Test plan
Bench parameters: OPEN_THRESH=1000, DEBOUNCE_SAMPLES=3, TURN_CYCLES=8, AROUND_CYCLES=16, SETTLE_CYCLES=4.
- Reset, then enable_in=1 → FORWARD one cycle later; setpoints 100/100; enables 1; directions 1/1.
- Three strobes with right_ir=1500, forward_ir=0, left_ir=0 → TURN_RIGHT after the third strobe; setpoints 100/50; busy_out=1 for exactly 8+4 cycles; then FORWARD.
- Two strobes with right open, then one with all closed → no turn; then two more all-closed strobes → TURN_AROUND, right direction 0, for 16 cycles.
- right_ir=1000 (equal to threshold) with forward_ir=2000 for 3 strobes → stays in FORWARD; left_ir=1001 alone → TURN_LEFT with setpoints 50/100.
- enable_in dropped during cycle 3 of TURN_LEFT → IDLE on the next edge with outputs zeroed; re-enable → a fresh 3-strobe debounce is required.
- reset_n_in pulsed low mid-TURN_AROUND between clock edges → outputs reach IDLE values before the next edge.
